// File: rtl/pll_audio_cfg_if.sv
// Avalon-MM write-only management bus between the PLL retune sequencer and the reconfig IP.
interface pll_audio_cfg_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_audio_cfg.sv
// Retunes the audio PLL between 24.576 MHz and 22.5792 MHz: six reconfig writes, settle, relock wait.
// First write 1 cycle after req; writes held while waitrequest is high; one-deep last-wins pending request.
module pll_audio_cfg #(
  parameter logic        INIT_SEL     = 1'b0,
  parameter logic [31:0] N_DATA       = 32'h0001_0000,
  parameter logic [31:0] M48_DATA     = 32'h0000_0606,
  parameter logic [31:0] M44_DATA     = 32'h0000_0606,
  parameter logic [31:0] K48_DATA     = 32'd1236950581,
  parameter logic [31:0] K44_DATA     = 32'd827932256,
  parameter logic [31:0] C48_DATA     = 32'h0002_0D0C,
  parameter logic [31:0] C44_DATA     = 32'h0002_0E0D,
  parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            rate_sel,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            cur_sel,
  output logic            audio_mute,
  input  logic            pll_locked,
  pll_audio_cfg_if.master mgmt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_SETTLE,
    S_LOCKWAIT,
    S_FIN
  } state_t;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [19:0] cnt_q;
  logic        tgt_q;
  logic        pend_vld_q;
  logic        pend_sel_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic        cur_sel_q;
  logic        mute_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        wr_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;

  logic [5:0]  addr_d;
  logic [31:0] data_d;
  logic        start_d;
  logic        sel_d;
  logic        skip_d;

  // Write word for the current index; index 0 is loaded directly on leaving IDLE.
  always_comb begin
    addr_d = 6'd0;
    data_d = 32'd0;
    unique case (idx_q)
      3'd0: begin addr_d = 6'd0; data_d = 32'd0;                         end
      3'd1: begin addr_d = 6'd3; data_d = N_DATA;                        end
      3'd2: begin addr_d = 6'd4; data_d = tgt_q ? M44_DATA : M48_DATA;   end
      3'd3: begin addr_d = 6'd5; data_d = tgt_q ? C44_DATA : C48_DATA;   end
      3'd4: begin addr_d = 6'd7; data_d = tgt_q ? K44_DATA : K48_DATA;   end
      3'd5: begin addr_d = 6'd2; data_d = 32'd0;                         end
      default: begin addr_d = 6'd0; data_d = 32'd0;                      end
    endcase
  end

  // A fresh strobe in IDLE is newer than anything left pending.
  assign start_d = req | pend_vld_q;
  assign sel_d   = req ? rate_sel : pend_sel_q;
  assign skip_d  = (sel_d == cur_sel_q) && !error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= 20'd0;
      tgt_q      <= INIT_SEL;
      pend_vld_q <= 1'b0;
      pend_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cur_sel_q  <= INIT_SEL;
      mute_q     <= 1'b1;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 6'd0;
      data_q     <= 32'd0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
      mute_q  <= busy_q | ~sync2_q;
      done_q  <= 1'b0;

      if (state_q != S_IDLE && req) begin
        pend_vld_q <= 1'b1;
        pend_sel_q <= rate_sel;
      end

      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            pend_vld_q <= 1'b0;
            if (skip_d) begin
              done_q <= 1'b1;
            end else begin
              tgt_q   <= sel_d;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              idx_q   <= 3'd0;
              wr_q    <= 1'b1;
              addr_q  <= 6'd0;
              data_q  <= 32'd0;
              state_q <= S_WR;
            end
          end
        end

        S_WR: begin
          if (wr_q) begin
            if (!mgmt.mgmt_waitrequest) begin
              wr_q <= 1'b0;
              if (idx_q == 3'd5) begin
                cnt_q   <= 20'd0;
                state_q <= S_SETTLE;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end else begin
            wr_q   <= 1'b1;
            addr_q <= addr_d;
            data_q <= data_d;
          end
        end

        // Ignore whatever locked value the PLL reports while it is still reacting to start.
        S_SETTLE: begin
          if (cnt_q == 20'd15) begin
            cnt_q   <= 20'd0;
            state_q <= S_LOCKWAIT;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

        S_LOCKWAIT: begin
          if (sync2_q) begin
            cur_sel_q <= tgt_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_FIN;
          end else if (cnt_q == LOCK_TIMEOUT - 20'd1) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign cur_sel             = cur_sel_q;
  assign audio_mute          = mute_q;
  assign mgmt.mgmt_write     = wr_q;
  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_writedata = data_q;

endmodule

// File: doc/pll_audio_cfg.md
# pll_audio_cfg

Sequencing controller that retunes the audio PLL between the 48 kHz family (24.576 MHz) and the 44.1 kHz family (22.5792 MHz) through the Avalon-MM management port of the PLL reconfiguration block. It sits between the audio subsystem and the PLL's reconfig IP: it accepts a rate-family request, writes the N/M/C0/K counter set and the start command, waits for relock, and mutes audio while the clock is unstable.

## Interface
Parameters:
- INIT_SEL, 1'b0: family the PLL powers up in (0 = 24.576 MHz, 1 = 22.5792 MHz).
- N_DATA, 32'h0001_0000: N counter word, bypass (N = 1); same for both families.
- M48_DATA, 32'h0000_0606: M counter word for M = 12, 48k family.
- M44_DATA, 32'h0000_0606: M counter word for M = 12, 44.1k family.
- K48_DATA, 32'd1236950581: fractional K, 0.288 × 2^32.
- K44_DATA, 32'd827932256: fractional K, 0.192768 × 2^32.
- C48_DATA, 32'h0002_0D0C: C0 = 25 (odd, high 13, low 12); VCO 614.4 MHz.
- C44_DATA, 32'h0002_0E0D: C0 = 27 (odd, high 14, low 13); VCO 609.6384 MHz.
- LOCK_TIMEOUT, 20'd1000000: cycles allowed for relock.

Ports:
- clk  in  1  management clock (50 MHz); the only clock.
- reset  in  1  synchronous, active-high.
- req  in  1  single-cycle request strobe.
- rate_sel  in  1  requested family, sampled with req.
- busy  out  1  reconfiguration in progress.
- done  out  1  one-cycle pulse on successful completion or skip.
- error  out  1  sticky lock-timeout flag; cleared by the next accepted request.
- cur_sel  out  1  family currently programmed.
- audio_mute  out  1  audio clock not trustworthy.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_waitrequest  in  1  reconfig stall.
- pll_locked  in  1  PLL locked; asynchronous, double-flop synchronised internally.

## Operation
- States: IDLE, WR, SETTLE, LOCKWAIT, FIN.
- IDLE:
  - On req with rate_sel == cur_sel and error == 0: skip, no bus activity; done pulses the next cycle.
  - Otherwise latch rate_sel into tgt, clear error, set busy, enter WR with index 0.
- WR performs six writes in order, using the tgt data set:
  - addr 0 ← 0 (waitrequest mode)
  - addr 3 ← N_DATA
  - addr 4 ← M
  - addr 5 ← C0
  - addr 7 ← K
  - addr 2 ← 0 (start)
- WR to SETTLE after the start write is accepted.
- SETTLE: wait 16 cycles so that a stale locked value is ignored, then enter LOCKWAIT.
- LOCKWAIT:
  - Synchronised locked = 1: cur_sel ← tgt, go to FIN.
  - Counter reaches LOCK_TIMEOUT: set error, leave cur_sel unchanged, go to FIN.
- FIN: done = 1 for one cycle only if error == 0; busy cleared; return to IDLE.
- Pending slot, one deep:
  - A req arriving while busy stores its rate_sel and overwrites any older pending request (last request wins).
  - On return to IDLE, the pending request is processed as if req had just arrived.
- audio_mute = busy | ~locked_sync, registered.

## Timing
- Reset values:
  - state IDLE; mgmt_write 0; mgmt_address 0; mgmt_writedata 0.
  - busy 0; done 0; error 0; cur_sel = INIT_SEL; pending empty.
  - sync flops 0; audio_mute 1.
- Avalon write handshake:
  - mgmt_write, address and data are registered and held stable while mgmt_waitrequest = 1.
  - A transfer completes on the edge where mgmt_write = 1 and mgmt_waitrequest = 0.
  - mgmt_write is low for exactly one cycle between consecutive writes.
- Latency with zero waitrequest: req edge to first mgmt_write = 1 cycle; six writes in 12 cycles.
- Latency after the start write is accepted:
  - 16 settle cycles;
  - then locked_sync needs 2 cycles after pll_locked rises;
  - done is asserted on the following cycle.
- Skip path: done is asserted 1 cycle after req; busy stays 0.
- A req arriving in the same cycle as FIN is captured into pending, not lost.
- Reset mid-write drops mgmt_write on that edge and returns to IDLE with cur_sel = INIT_SEL. Software must re-request after any reset.

## Test plan
- Request 44.1k family, no stalls, immediate lock -> writes to addresses 0, 3, 4, 5, 7, 2 with data 0, 0x10000, 0x0606, 0x20E0D, 827932256, 0; cur_sel = 1; done pulses once; audio_mute low again after lock.
- Same request with mgmt_waitrequest held high 5 cycles on the M write -> address and data stable throughout the stall; no duplicate write; sequence otherwise unchanged.
- req with rate_sel = cur_sel after success -> zero bus writes; done 1 cycle later; busy never asserted.
- pll_locked held low, LOCK_TIMEOUT = 100 -> error = 1 after 16 + 100 cycles; no done; cur_sel unchanged; a retry clears error and completes.
- Two reqs (1 then 0) arriving during busy -> only the last (0) runs after the first sequence completes; two done pulses in total.
- reset asserted during the C0 write -> mgmt_write = 0 on the next edge; outputs at reset values; a subsequent request runs the full sequence.
